// File: rtl/piso_serializer_if.sv
// piso_serializer_if: handshake and serial-output bundle for piso_serializer.
//   din        parallel word offered by upstream
//   din_valid  upstream has a word on din
//   din_ready  serializer can take a word this cycle
//   sout       serial data bit towards the shift chain
//   sout_valid sout carries a real data bit
//   frame      first bit of a word is on sout
//   busy       serializer is shifting a word
// master: upstream / observer side; slave: the serializer itself.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, frame, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, frame, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out converter feeding a serial shift chain.
// Takes a WIDTH-bit word on a valid/ready handshake and emits one bit per clock,
// MSB or LSB first. Back-to-back words stream with no idle bit; frame marks bit 0.
// Ports:
//   clk      rising-edge system clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of piso_serializer_if (din, din_valid, din_ready,
//            sout, sout_valid, frame, busy)
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  piso_serializer_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             frame_q, frame_d;

  logic last_bit;
  logic accept;

  assign last_bit      = (state_q == StShift) && (cnt_q == CntLast);
  // Ready on the last bit lets the next word load with no gap cycle.
  assign bus.din_ready = (state_q == StIdle) || last_bit;
  assign accept        = bus.din_valid && bus.din_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    if (accept) begin
      state_d = StShift;
      shreg_d = bus.din;
      cnt_d   = '0;
      frame_d = 1'b1;
    end else if (state_q == StShift) begin
      if (last_bit) begin
        state_d = StIdle;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        // Move the next bit toward the output end, zero-filling behind it.
        if (MSB_FIRST) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // All serial outputs come straight from flops; the register is zero in idle.
  assign bus.sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.sout_valid = (state_q == StShift);
  assign bus.busy       = (state_q == StShift);
  assign bus.frame      = frame_q;

endmodule
